// File: rtl/rr_mem_port_arb_if.sv
// Bundle of requester-side and downstream memory-port signals for rr_mem_port_arb.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface rr_mem_port_arb_if #(
  parameter int N_REQ   = 2,
  parameter int LINE_AW = 10,
  parameter int LINE_DW = 512
);
  logic [N_REQ-1:0]         req_i;
  logic [N_REQ-1:0]         we_i;
  logic [N_REQ*LINE_AW-1:0] addr_i;
  logic [N_REQ*LINE_DW-1:0] wdata_i;
  logic [N_REQ-1:0]         ack_o;
  logic [N_REQ-1:0]         err_o;
  logic [LINE_DW-1:0]       rdata_o;
  logic [N_REQ-1:0]         grant_o;
  logic                     busy_o;
  logic                     rcyc_o;
  logic                     wcyc_o;
  logic [LINE_AW-1:0]       raddr_o;
  logic [LINE_AW-1:0]       waddr_o;
  logic [LINE_DW-1:0]       wdata_o;
  logic                     ack_i;
  logic [LINE_DW-1:0]       rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, ack_i, rdata_i,
    output ack_o, err_o, rdata_o, grant_o, busy_o,
           rcyc_o, wcyc_o, raddr_o, waddr_o, wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, ack_i, rdata_i,
    input  ack_o, err_o, rdata_o, grant_o, busy_o,
           rcyc_o, wcyc_o, raddr_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/rr_mem_port_arb.sv
// Round-robin arbiter/sequencer for the single line-wide main-memory port,
// with a per-access watchdog that aborts unacknowledged accesses.
module rr_mem_port_arb #(
  parameter int N_REQ   = 2,
  parameter int LINE_AW = 10,
  parameter int LINE_DW = 512,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  rr_mem_port_arb_if.slave  arb_if
);

  localparam int unsigned NR = N_REQ;
  localparam int unsigned GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      g_q, g_d;
  logic               we_q, we_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [LINE_AW-1:0] addr_q, addr_d;
  logic [LINE_DW-1:0] wdata_q, wdata_d;
  logic [LINE_DW-1:0] rdata_q, rdata_d;

  logic               found;
  logic [GW-1:0]      pick;
  int unsigned        idx;
  logic [N_REQ-1:0]   grant_oh;

  // Circular scan starting at ptr; the wrap is explicit so non-power-of-two N_REQ works.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NR) idx = idx - NR;
      if (!found && arb_if.req_i[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          g_d     = pick;
          we_d    = arb_if.we_i[pick];
          addr_d  = arb_if.addr_i[pick*LINE_AW +: LINE_AW];
          wdata_d = arb_if.wdata_i[pick*LINE_DW +: LINE_DW];
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        // A completion in the limit cycle takes precedence over the abort.
        if (arb_if.ack_i) begin
          if (!we_q) rdata_d = arb_if.rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (g_q == GW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    grant_oh        = '0;
    grant_oh[g_q]   = 1'b1;
    arb_if.grant_o  = (state_q != IDLE) ? grant_oh : '0;
    arb_if.ack_o    = (state_q == RESP) ? grant_oh : '0;
    arb_if.err_o    = (state_q == RESP && err_q) ? grant_oh : '0;
    arb_if.busy_o   = (state_q != IDLE);
    arb_if.rcyc_o   = (state_q == BUSY) && !we_q;
    arb_if.wcyc_o   = (state_q == BUSY) && we_q;
    arb_if.raddr_o  = ((state_q == BUSY) && !we_q) ? addr_q : '0;
    arb_if.waddr_o  = ((state_q == BUSY) && we_q) ? addr_q : '0;
    arb_if.wdata_o  = ((state_q == BUSY) && we_q) ? wdata_q : '0;
    arb_if.rdata_o  = rdata_q;
  end

endmodule

// File: tb/tb_rr_mem_port_arb.sv
// Bench for rr_mem_port_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_rr_mem_port_arb;
  localparam int NR = 3;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rr_mem_port_arb_if #(.N_REQ(NR), .LINE_AW(AW), .LINE_DW(DW)) bus ();

  rr_mem_port_arb #(.N_REQ(NR), .LINE_AW(AW), .LINE_DW(DW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .arb_if (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = waiting, 1 = access in flight, 2 = reply cycle.
  int            m_mode = 0, m_last = NR - 1, m_g = 0, m_busy_n = 0, m_c = 0;
  bit            m_we = 1'b0, m_err = 1'b0, m_found = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [NR-1:0] m_oh;

  always @(posedge clk) begin
    if (!resetn) begin
      m_mode = 0; m_last = NR - 1; m_rdata = '0; m_err = 1'b0;
    end else if (m_mode == 0) begin
      m_found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        m_c = (m_last + k) % NR;
        if (!m_found && bus.req_i[m_c]) begin m_found = 1'b1; m_g = m_c; end
      end
      if (m_found) begin
        m_we = bus.we_i[m_g];
        m_addr = bus.addr_i[m_g*AW +: AW];
        m_wdata = bus.wdata_i[m_g*DW +: DW];
        m_busy_n = 1;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (bus.ack_i) begin
        if (!m_we) m_rdata = bus.rdata_i;
        m_err = 1'b0; m_mode = 2;
      end else if (m_busy_n == TO) begin
        m_err = 1'b1; m_mode = 2;
      end else m_busy_n++;
    end else begin
      m_last = m_g; m_mode = 0;
    end
    #1;
    m_oh = '0;
    if (m_mode != 0) m_oh[m_g] = 1'b1;
    chk("m_grant", bus.grant_o, m_oh);
    chk("m_busy", bus.busy_o, m_mode != 0);
    chk("m_rcyc", bus.rcyc_o, m_mode == 1 && !m_we);
    chk("m_wcyc", bus.wcyc_o, m_mode == 1 && m_we);
    chk("m_ack", bus.ack_o, (m_mode == 2) ? m_oh : '0);
    chk("m_err", bus.err_o, (m_mode == 2 && m_err) ? m_oh : '0);
    chk("m_rdata", bus.rdata_o, m_rdata);
    if (m_mode == 1) begin
      chk("m_raddr", bus.raddr_o, m_we ? '0 : m_addr);
      chk("m_waddr", bus.waddr_o, m_we ? m_addr : '0);
      if (m_we) chk("m_wdata", bus.wdata_o, m_wdata);
    end
  end

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a);
    bus.req_i[i] = 1'b1;
    bus.we_i[i] = w;
    bus.addr_i[i*AW +: AW] = a;
    bus.wdata_i[i*DW +: DW] = {$urandom, $urandom};
  endtask

  // Waits for the next grant, acks it in busy cycle 'lat' (0 = never), checks the reply.
  task automatic serve(input int gidx, input int lat, input bit keep,
                       input logic [NR-1:0] raise, input bit exp_we, input logic [AW-1:0] exp_addr);
    int n;
    int exp_n;
    bit got;
    logic [NR-1:0] oh;
    logic [DW-1:0] rd;
    oh = '0; oh[gidx] = 1'b1; got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (bus.grant_o != '0) got = 1'b1;
    end
    chk("grant_seen", got, 1);
    chk("grant", bus.grant_o, oh);
    chk("cyc_kind", {bus.wcyc_o, bus.rcyc_o}, exp_we ? 2'b10 : 2'b01);
    chk("bus_addr", exp_we ? bus.waddr_o : bus.raddr_o, exp_addr);
    bus.req_i = bus.req_i | raise;
    n = 0;
    while ((bus.rcyc_o || bus.wcyc_o) && n < 20) begin
      n++;
      if (n == lat) begin
        rd = {$urandom, $urandom};
        bus.ack_i = 1'b1; bus.rdata_i = rd;
        if (!exp_we) last_rd = rd;
      end else bus.ack_i = 1'b0;
      @(negedge clk);
    end
    bus.ack_i = 1'b0;
    exp_n = (lat >= 1 && lat <= TO) ? lat : TO;
    chk("busy_cycles", n, exp_n);
    chk("ack", bus.ack_o, oh);
    chk("err", bus.err_o, (lat >= 1 && lat <= TO) ? '0 : oh);
    chk("rdata", bus.rdata_o, last_rd);
    if (!keep) bus.req_i[gidx] = 1'b0;
  endtask

  initial begin
    bit got;
    bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    bus.ack_i = 1'b0; bus.rdata_i = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", bus.ack_o, 0);      chk("rst_err", bus.err_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);  chk("rst_grant", bus.grant_o, 0);
    chk("rst_busy", bus.busy_o, 0);    chk("rst_rcyc", bus.rcyc_o, 0);
    chk("rst_wcyc", bus.wcyc_o, 0);    chk("rst_raddr", bus.raddr_o, 0);
    chk("rst_waddr", bus.waddr_o, 0);  chk("rst_wdata", bus.wdata_o, 0);
    resetn = 1'b1;

    // Single read, acked in the third busy cycle.
    set_req(0, 1'b0, 10'h02A);
    serve(0, 3, 1'b0, '0, 1'b0, 10'h02A);

    // Rotation from ptr=1 with req=101; requester 1 joins during 0's access.
    set_req(0, 1'b1, 10'h011);
    set_req(2, 1'b0, 10'h3C0);
    bus.we_i[1] = 1'b0; bus.addr_i[1*AW +: AW] = 10'h155;
    serve(2, 1, 1'b1, '0, 1'b0, 10'h3C0);
    serve(0, 2, 1'b0, 3'b010, 1'b1, 10'h011);
    serve(1, 1, 1'b0, '0, 1'b0, 10'h155);
    serve(2, 1, 1'b0, '0, 1'b0, 10'h3C0);

    // Timeout on a write, then a stray ack that must not disturb anything.
    set_req(1, 1'b1, 10'h0F0);
    serve(1, 0, 1'b0, '0, 1'b1, 10'h0F0);
    @(negedge clk);
    bus.ack_i = 1'b1; bus.rdata_i = {$urandom, $urandom};
    @(negedge clk);
    bus.ack_i = 1'b0;
    chk("stray_ack", bus.ack_o, 0);
    chk("stray_rdata", bus.rdata_o, last_rd);
    chk("stray_busy", bus.busy_o, 0);

    // Ack in the limit cycle wins over the abort.
    set_req(0, 1'b0, 10'h02B);
    serve(0, TO, 1'b0, '0, 1'b0, 10'h02B);

    // Reset in the second busy cycle.
    set_req(2, 1'b0, 10'h001);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      if (bus.grant_o != '0) got = 1'b1;
    end
    chk("rstb_grant_seen", got, 1);
    @(negedge clk);
    chk("rstb_rcyc_before", bus.rcyc_o, 1);
    resetn = 1'b0; bus.req_i = '0;
    @(negedge clk);
    chk("rstb_rcyc", bus.rcyc_o, 0);
    chk("rstb_grant", bus.grant_o, 0);
    chk("rstb_ack", bus.ack_o, 0);
    resetn = 1'b1;
    set_req(0, 1'b0, 10'h100);
    set_req(1, 1'b1, 10'h200);
    serve(0, 1, 1'b0, '0, 1'b0, 10'h100);
    serve(1, 1, 1'b0, '0, 1'b1, 10'h200);

    // Randomized traffic, checked by the model process.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      resetn = ($urandom_range(0, 199) != 0);
      if (!resetn) bus.req_i = '0;
      for (int i = 0; i < NR; i++) begin
        if (bus.req_i[i] && bus.ack_o[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, 1'($urandom), 10'($urandom));
          else bus.req_i[i] = 1'b0;
        end else if (bus.req_i[i] && bus.grant_o[i] && $urandom_range(0, 49) == 0) begin
          bus.req_i[i] = 1'b0;
        end else if (resetn && !bus.req_i[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom), 10'($urandom));
        end
      end
      bus.ack_i = ($urandom_range(0, 2) == 0);
      bus.rdata_i = {$urandom, $urandom};
    end
    @(negedge clk);
    bus.req_i = '0; bus.ack_i = 1'b0;
    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
